// File: rtl/fetch_ctrl_if.sv
// Fetch bus: instruction-memory port, decode handshake, redirect request and status.
// The master modport is the fetch sequencer's view; slave is the surrounding system.
interface fetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_out;
   logic [31:0] ins_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        fault;

   modport master (
      output imem_addr, ins_valid, ins_out, ins_pc, halted, fault,
      input  imem_data, ins_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, ins_valid, ins_out, ins_pc, halted, fault,
      output imem_data, ins_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, buffers {pc, word} pairs in a small FIFO,
// and handles redirects, end-of-memory halt and misaligned-redirect faults.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int unsigned MEM_BYTES = 80,
   parameter int unsigned DEPTH     = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_ctrl_if.master bus
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_fifo_ins [DEPTH];
   logic [31:0] r_fifo_pc  [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_in_range;
   logic w_redirect;
   logic w_misaligned;
   logic w_fetch_en;
   logic w_flush;
   logic w_halted;
   logic w_fault;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign w_empty      = (r_wr_ptr == r_rd_ptr);
   assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop        = !w_empty && bus.ins_ready;
   assign w_in_range   = (r_pc <= LAST_PC);
   assign w_redirect   = bus.redirect_valid && (r_state != ST_FAULT);
   assign w_misaligned = (bus.redirect_pc[1:0] != 2'b00);

   // NOTE: sequential state is updated with non-blocking (<=) assignments so every
   // register samples the pre-edge values, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: each always_comb assigns a default first so no path leaves a signal
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (w_redirect) begin
         if (w_misaligned) begin
            w_state_nxt = ST_FAULT;
         end else if (bus.redirect_pc <= LAST_PC) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_state_nxt = ST_HALT;
         end
      end else begin
         case (r_state)
            ST_RUN:  if (!w_in_range) w_state_nxt = ST_HALT;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FAULT;
         endcase
      end
   end

   always_comb begin
      w_fetch_en = 1'b0;
      w_flush    = 1'b0;
      w_halted   = 1'b0;
      w_fault    = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_fetch_en = !w_redirect && w_in_range && (!w_full || w_pop);
            w_flush    = w_redirect;
         end
         ST_HALT: begin
            w_flush  = w_redirect;
            w_halted = w_empty;
         end
         default: begin
            w_flush = 1'b1;
            w_fault = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (w_redirect && !w_misaligned) begin
         r_pc <= bus.redirect_pc;
      end else if (w_fetch_en) begin
         r_pc <= r_pc + 32'd4;
      end
   end

   // A redirect flushes everything, including a head popped in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_fetch_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)      r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // NOTE: the storage array is reset because ins_out/ins_pc read it directly and
   // must show zero out of reset; at this depth the cost is a few flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_fifo_ins[i] <= '0;
            r_fifo_pc[i]  <= '0;
         end
      end else if (w_fetch_en) begin
         r_fifo_ins[r_wr_ptr[AW-1:0]] <= bus.imem_data;
         r_fifo_pc[r_wr_ptr[AW-1:0]]  <= r_pc;
      end
   end

   assign bus.imem_addr = r_pc;
   assign bus.ins_valid = !w_empty && !w_fault;
   assign bus.ins_out   = r_fifo_ins[r_rd_ptr[AW-1:0]];
   assign bus.ins_pc    = r_fifo_pc[r_rd_ptr[AW-1:0]];
   assign bus.halted    = w_halted;
   assign bus.fault     = w_fault;

endmodule
